// File: rtl/booth_multiplier.sv
// Multi-cycle signed WIDTHxWIDTH multiplier using radix-2 Booth recoding.
// start/busy/done handshake; product holds until the next completion.
module booth_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       mcand;
    logic [WIDTH:0]       neg_mcand;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     q;
    logic                 q_1;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH+1:0]   shifted;
    logic [WIDTH:0]       acc_next;
    logic [WIDTH-1:0]     q_next;
    logic                 q_1_next;
    logic                 accept;
    logic                 last_step;

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        sum = acc;
        unique case ({q[0], q_1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc + neg_mcand;
            default: sum = acc;
        endcase
    end

    // Arithmetic right shift of {acc, q, q_1}, replicating the acc sign bit
    assign shifted  = {sum[WIDTH], sum, q};
    assign acc_next = shifted[2*WIDTH+1:WIDTH+1];
    assign q_next   = shifted[WIDTH:1];
    assign q_1_next = shifted[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            q         <= '0;
            q_1       <= 1'b0;
            mcand     <= '0;
            neg_mcand <= '0;
            cnt       <= '0;
            product   <= '0;
        end else if (accept) begin
            // acc is one bit wider so -(most negative A) still fits
            mcand     <= {A[WIDTH-1], A};
            neg_mcand <= ~{A[WIDTH-1], A} + 1'b1;
            q         <= B;
            acc       <= '0;
            q_1       <= 1'b0;
            cnt       <= '0;
        end else if (state == RUN) begin
            acc <= acc_next;
            q   <= q_next;
            q_1 <= q_1_next;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                product <= {acc_next[WIDTH-1:0], q_next};
            end
        end
    end

endmodule
